// File: rtl/issue_scoreboard.sv
// Issue stage: holds the decoded instruction, reads the register file, checks
// RAW/WAW hazards against a per-register pending scoreboard and write-port
// conflicts against a writeback-slot reservation shift register, then either
// dispatches to a functional unit or inserts a bubble and stalls decode.
module issue_scoreboard #(
  parameter int LAT_ALU = 1,
  parameter int LAT_MEM = 4,
  parameter int LAT_MUL = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_is_valid,
  input  logic [1:0]  id_is_functionalunit,
  input  logic [4:0]  id_is_rs,
  input  logic [4:0]  id_is_rt,
  input  logic        id_is_userega,
  input  logic        id_is_useregb,
  input  logic [4:0]  id_is_regdest,
  input  logic        id_is_writereg,
  input  logic [2:0]  id_is_aluop,
  input  logic        id_is_unsig,
  input  logic        id_is_readmem,
  input  logic        id_is_writemem,
  input  logic        id_is_selwsource,
  input  logic [31:0] id_is_imedext,
  output logic [4:0]  is_rf_addra,
  output logic [4:0]  is_rf_addrb,
  input  logic [31:0] rf_is_dataa,
  input  logic [31:0] rf_is_datab,
  input  logic [4:0]  wb_is_regdest,
  input  logic        wb_is_writereg,
  output logic        is_id_stall,
  output logic [1:0]  is_fu_functionalunit,
  output logic [2:0]  is_fu_aluop,
  output logic        is_fu_unsig,
  output logic        is_fu_readmem,
  output logic        is_fu_writemem,
  output logic        is_fu_selwsource,
  output logic [4:0]  is_fu_regdest,
  output logic        is_fu_writereg,
  output logic [31:0] is_fu_rega,
  output logic [31:0] is_fu_regb,
  output logic [31:0] is_fu_imedext
);

  localparam int LAT_AM  = (LAT_ALU > LAT_MEM) ? LAT_ALU : LAT_MEM;
  localparam int LAT_MAX = (LAT_AM > LAT_MUL) ? LAT_AM : LAT_MUL;

  // One-hot masks selecting the reservation bit that a unit's writeback would use.
  localparam logic [LAT_MAX:0] SLOT_ONE = 1;
  localparam logic [LAT_MAX:0] MASK_ALU = SLOT_ONE << LAT_ALU;
  localparam logic [LAT_MAX:0] MASK_MEM = SLOT_ONE << LAT_MEM;
  localparam logic [LAT_MAX:0] MASK_MUL = SLOT_ONE << LAT_MUL;

  logic [31:0]      pending;
  logic [31:0]      pending_next;
  logic [LAT_MAX:0] wbslot;
  logic [LAT_MAX:0] wbslot_next;
  logic [LAT_MAX:0] lat_mask;
  logic             is_nop;
  logic             raw_a;
  logic             raw_b;
  logic             waw;
  logic             port_busy;
  logic             hazard;
  logic             dispatch;

  // Register-file read addresses come straight from decode.
  assign is_rf_addra = id_is_rs;
  assign is_rf_addrb = id_is_rt;

  // Select the writeback-slot mask for the requested unit; a nop has none.
  always_comb begin
    lat_mask = '0;
    case (id_is_functionalunit)
      2'd0:    lat_mask = MASK_ALU;
      2'd1:    lat_mask = MASK_MEM;
      2'd2:    lat_mask = MASK_MUL;
      default: lat_mask = '0;
    endcase
  end

  // Hazard detection against registered state only (no same-cycle writeback bypass).
  always_comb begin
    is_nop    = (id_is_functionalunit == 2'd3);
    raw_a     = id_is_userega  & (id_is_rs != 5'd0)      & pending[id_is_rs];
    raw_b     = id_is_useregb  & (id_is_rt != 5'd0)      & pending[id_is_rt];
    waw       = id_is_writereg & (id_is_regdest != 5'd0) & pending[id_is_regdest];
    port_busy = id_is_writereg & (|(wbslot & lat_mask));
    hazard    = id_is_valid & ~is_nop & (raw_a | raw_b | waw | port_busy);
    dispatch  = id_is_valid & ~is_nop & ~hazard;
  end

  assign is_id_stall = hazard;

  // Next scoreboard state: writeback clears first, a new dispatch then sets (set wins).
  always_comb begin
    pending_next = pending;
    if (wb_is_writereg) begin
      pending_next[wb_is_regdest] = 1'b0;
    end
    if (dispatch && id_is_writereg && (id_is_regdest != 5'd0)) begin
      pending_next[id_is_regdest] = 1'b1;
    end
    wbslot_next = wbslot >> 1;
    if (dispatch && id_is_writereg) begin
      wbslot_next = wbslot_next | (lat_mask >> 1);
    end
  end

  // Scoreboard and writeback-slot reservation state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      wbslot  <= '0;
    end else begin
      pending <= pending_next;
      wbslot  <= wbslot_next;
    end
  end

  // Registered dispatch bus: instruction fields on dispatch, otherwise a bubble.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      is_fu_functionalunit <= 2'd3;
      is_fu_aluop          <= '0;
      is_fu_unsig          <= 1'b0;
      is_fu_readmem        <= 1'b0;
      is_fu_writemem       <= 1'b0;
      is_fu_selwsource     <= 1'b0;
      is_fu_regdest        <= '0;
      is_fu_writereg       <= 1'b0;
      is_fu_rega           <= '0;
      is_fu_regb           <= '0;
      is_fu_imedext        <= '0;
    end else if (dispatch) begin
      is_fu_functionalunit <= id_is_functionalunit;
      is_fu_aluop          <= id_is_aluop;
      is_fu_unsig          <= id_is_unsig;
      is_fu_readmem        <= id_is_readmem;
      is_fu_writemem       <= id_is_writemem;
      is_fu_selwsource     <= id_is_selwsource;
      is_fu_regdest        <= id_is_regdest;
      is_fu_writereg       <= id_is_writereg;
      is_fu_rega           <= rf_is_dataa;
      is_fu_regb           <= rf_is_datab;
      is_fu_imedext        <= id_is_imedext;
    end else begin
      is_fu_functionalunit <= 2'd3;
      is_fu_aluop          <= '0;
      is_fu_unsig          <= 1'b0;
      is_fu_readmem        <= 1'b0;
      is_fu_writemem       <= 1'b0;
      is_fu_selwsource     <= 1'b0;
      is_fu_regdest        <= '0;
      is_fu_writereg       <= 1'b0;
      is_fu_rega           <= '0;
      is_fu_regb           <= '0;
      is_fu_imedext        <= '0;
    end
  end

endmodule
